// File: rtl/scc_dac_pkg.sv
// rtl/scc_dac_pkg.sv - shared types, constants and sample scaling for the SCC delta-sigma DAC
package scc_dac_pkg;

    // Gain ramp controller states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RUN       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } gain_state_t;

    localparam int MIDSCALE  = 1024;
    localparam int GAIN_FULL = 256;
    localparam int I1_W      = 17;
    localparam int I2_W      = 19;

    // Signed sample (offset binary minus midscale) times gain/256, rounded toward
    // minus infinity. Gain 256 returns the sample unchanged, gain 0 returns 0.
    function automatic logic signed [11:0] scale_sample(input logic [10:0] sample,
                                                        input logic [8:0]  gain);
        logic signed [11:0] x;
        logic signed [21:0] prod;
        x    = $signed({1'b0, sample} - 12'(MIDSCALE));
        prod = x * $signed({1'b0, gain});
        return 12'(prod >>> 8);
    endfunction

endpackage

// File: rtl/scc_dsm2.sv
// rtl/scc_dsm2.sv - second-order delta-sigma integrators and comparator
//
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   tick        : update enable, one clk wide
//   u           : signed scaled sample, -1024..1023
//   dout        : modulator output bit (feedback +1024 when 1, -1024 when 0)
module scc_dsm2
    import scc_dac_pkg::*;
(
    input  logic               clk,
    input  logic               nreset,
    input  logic               tick,
    input  logic signed [11:0] u,
    output logic               dout
);

    localparam logic [I1_W-1:0] I1_POS = {1'b0, {(I1_W-1){1'b1}}};
    localparam logic [I1_W-1:0] I1_NEG = {1'b1, {(I1_W-1){1'b0}}};
    localparam logic [I2_W-1:0] I2_POS = {1'b0, {(I2_W-1){1'b1}}};
    localparam logic [I2_W-1:0] I2_NEG = {1'b1, {(I2_W-1){1'b0}}};

    logic [I1_W-1:0] i1;
    logic [I2_W-1:0] i2;
    logic [12:0]     fb;
    logic [I1_W:0]   i1_sum;
    logic [I2_W:0]   i2_sum;
    logic [I1_W-1:0] i1_nxt;
    logic [I2_W-1:0] i2_nxt;

    assign fb = dout ? 13'd1024 : 13'h1C00;  // +1024 / -1024

    // Sums are one bit wider than the integrator; a disagreement between the
    // top two bits is an overflow, which clamps toward the sum's sign.
    // The second stage integrates the freshly updated first stage, giving the
    // classic (1 - z^-1)^2 noise shaping.
    always_comb begin
        i1_sum = {i1[I1_W-1], i1}
               + {{(I1_W-11){u[11]}}, u}
               - {{(I1_W-12){fb[12]}}, fb};
        if (i1_sum[I1_W] != i1_sum[I1_W-1])
            i1_nxt = i1_sum[I1_W] ? I1_NEG : I1_POS;
        else
            i1_nxt = i1_sum[I1_W-1:0];

        i2_sum = {i2[I2_W-1], i2}
               + {{(I2_W-I1_W+1){i1_nxt[I1_W-1]}}, i1_nxt}
               - {{(I2_W-12){fb[12]}}, fb};
        if (i2_sum[I2_W] != i2_sum[I2_W-1])
            i2_nxt = i2_sum[I2_W] ? I2_NEG : I2_POS;
        else
            i2_nxt = i2_sum[I2_W-1:0];
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            i1   <= '0;
            i2   <= '0;
            dout <= 1'b0;
        end else if (tick) begin
            i1   <= i1_nxt;
            i2   <= i2_nxt;
            dout <= ~i2_nxt[I2_W-1];
        end
    end

endmodule

// File: rtl/scc_dsm_dac.sv
// rtl/scc_dsm_dac.sv - SCC audio delta-sigma DAC with soft mute gain ramp
//
// Ports:
//   clk, nreset : system clock, asynchronous active-low reset
//   sound_in    : unsigned 11-bit SCC mix sample, midscale 1024
//   mute        : 1 ramps gain to silence, 0 ramps gain to full scale
//   dac_out     : delta-sigma bitstream for the external RC filter
//   ramp_busy   : gain is ramping
//   running     : gain is at full scale
module scc_dsm_dac
    import scc_dac_pkg::*;
#(
    parameter int CE_DIV     = 2,
    parameter int RAMP_TICKS = 64
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [10:0] sound_in,
    input  logic        mute,
    output logic        dac_out,
    output logic        ramp_busy,
    output logic        running
);

    localparam logic [3:0] CNT_LAST  = 4'(CE_DIV - 1);
    localparam logic [9:0] STEP_LAST = 10'(RAMP_TICKS - 1);
    localparam logic [8:0] GAIN_MAX  = 9'(GAIN_FULL);

    logic [3:0]         tick_cnt;
    logic               tick;
    logic [10:0]        hold;
    logic [8:0]         gain;
    logic [9:0]         step_cnt;
    gain_state_t        state;
    logic               reversing;
    logic [9:0]         step_eff;
    logic               step_wrap;
    logic signed [11:0] u;

    // With CE_DIV = 1 the counter never leaves 0, so tick stays high.
    assign tick = (tick_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 4'd1;
    end

    // A reversing ramp treats its first tick as tick one of the new direction
    // with a cleared step count, so the gain never jumps.
    always_comb begin
        reversing = 1'b0;
        if ((state == ST_RAMP_UP && mute) || (state == ST_RAMP_DOWN && !mute))
            reversing = 1'b1;
        step_eff  = reversing ? 10'd0 : step_cnt;
        step_wrap = (step_eff == STEP_LAST);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold      <= 11'(MIDSCALE);
            gain      <= '0;
            step_cnt  <= '0;
            state     <= ST_IDLE;
            ramp_busy <= 1'b0;
            running   <= 1'b0;
        end else if (tick) begin
            hold <= sound_in;
            case (state)
                ST_IDLE: begin
                    gain     <= '0;
                    step_cnt <= '0;
                    if (!mute) begin
                        state     <= ST_RAMP_UP;
                        ramp_busy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    gain     <= GAIN_MAX;
                    step_cnt <= '0;
                    if (mute) begin
                        state     <= ST_RAMP_DOWN;
                        ramp_busy <= 1'b1;
                        running   <= 1'b0;
                    end
                end
                ST_RAMP_UP, ST_RAMP_DOWN: begin
                    if (!mute) begin
                        if (gain == GAIN_MAX) begin
                            state     <= ST_RUN;
                            step_cnt  <= '0;
                            ramp_busy <= 1'b0;
                            running   <= 1'b1;
                        end else if (step_wrap) begin
                            gain     <= gain + 9'd1;
                            step_cnt <= '0;
                            if (gain == GAIN_MAX - 9'd1) begin
                                state     <= ST_RUN;
                                ramp_busy <= 1'b0;
                                running   <= 1'b1;
                            end else begin
                                state <= ST_RAMP_UP;
                            end
                        end else begin
                            step_cnt <= step_eff + 10'd1;
                            state    <= ST_RAMP_UP;
                        end
                    end else begin
                        if (gain == 9'd0) begin
                            state     <= ST_IDLE;
                            step_cnt  <= '0;
                            ramp_busy <= 1'b0;
                        end else if (step_wrap) begin
                            gain     <= gain - 9'd1;
                            step_cnt <= '0;
                            if (gain == 9'd1) begin
                                state     <= ST_IDLE;
                                ramp_busy <= 1'b0;
                            end else begin
                                state <= ST_RAMP_DOWN;
                            end
                        end else begin
                            step_cnt <= step_eff + 10'd1;
                            state    <= ST_RAMP_DOWN;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    gain      <= '0;
                    step_cnt  <= '0;
                    ramp_busy <= 1'b0;
                    running   <= 1'b0;
                end
            endcase
        end
    end

    assign u = scale_sample(hold, gain);

    scc_dsm2 u_dsm2 (
        .clk    (clk),
        .nreset (nreset),
        .tick   (tick),
        .u      (u),
        .dout   (dac_out)
    );

endmodule

// File: tb/tb_scc_dsm_dac.sv
// tb/tb_scc_dsm_dac.sv - directed self-checking bench for scc_dsm_dac
module tb_scc_dsm_dac;
    import scc_dac_pkg::*;

    localparam int CE_DIV     = 2;
    localparam int RAMP_TICKS = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [10:0] sound_in = 11'd1024;
    logic        mute = 1'b1;
    logic        dac_out;
    logic        ramp_busy;
    logic        running;

    int errors = 0;
    int checks = 0;

    int m_i1, m_i2, m_hold, eg, last_sample;
    bit m_dac;
    int ones;

    always #5 clk = ~clk;

    scc_dsm_dac #(
        .CE_DIV     (CE_DIV),
        .RAMP_TICKS (RAMP_TICKS)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .sound_in  (sound_in),
        .mute      (mute),
        .dac_out   (dac_out),
        .ramp_busy (ramp_busy),
        .running   (running)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_i1 = 0; m_i2 = 0; m_dac = 1'b0; m_hold = 1024;
    endtask

    // Reference modulator step: uses the sample held from the previous tick,
    // then latches the sample taken at this tick.
    task automatic model_tick(input int sampled);
        int x, u, fb;
        x      = m_hold - 1024;
        u      = (x * eg) >>> 8;
        fb     = m_dac ? 1024 : -1024;
        m_i1   = clamp(m_i1 + u - fb, -65536, 65535);
        m_i2   = clamp(m_i2 + m_i1 - fb, -262144, 262143);
        m_dac  = (m_i2 >= 0);
        m_hold = sampled;
    endtask

    // One tick period (CE_DIV = 2): value a is present at the non-tick edge,
    // value b at the tick edge. Returns 1 time unit after the tick edge.
    task automatic tick_step(input logic [10:0] a, input logic [10:0] b, input bit chk_hold);
        sound_in = a;
        @(posedge clk); #1;
        if (chk_hold) check("hold_between_ticks", int'(dut.hold), last_sample);
        sound_in = b;
        @(posedge clk); #1;
        last_sample = int'(b);
        if (chk_hold) check("hold_on_tick", int'(dut.hold), int'(b));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_step(11'd1024, 11'd1024, 1'b0);
    endtask

    task automatic run_model_ticks(input int n, input logic [10:0] v, input bit count);
        for (int i = 0; i < n; i++) begin
            tick_step(v, v, 1'b0);
            model_tick(int'(v));
            check("dac_vs_model", int'(dac_out), int'(m_dac));
            if (count) ones += int'(dac_out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        logic [10:0] a, b;
        last_sample = 1024;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_dac_out", int'(dac_out), 0);
        check("rst_ramp_busy", int'(ramp_busy), 0);
        check("rst_running", int'(running), 0);
        check("rst_gain", int'(dut.gain), 0);
        check("rst_hold", int'(dut.hold), 1024);
        @(negedge clk);
        nreset = 1'b1;

        // Muted: stays idle
        ticks(5);
        check("idle_muted_busy", int'(ramp_busy), 0);
        check("idle_muted_gain", int'(dut.gain), 0);

        // Unmute: first tick enters RAMP_UP at gain 0
        mute = 1'b0;
        ticks(1);
        check("up_enter_busy", int'(ramp_busy), 1);
        check("up_enter_gain", int'(dut.gain), 0);
        check("up_enter_running", int'(running), 0);
        ticks(400);
        check("up_gain_100", int'(dut.gain), 100);

        // Reverse at gain 100: 99 after 4 ticks, 0 and IDLE after 400
        mute = 1'b1;
        ticks(3);
        check("rev_gain_hold", int'(dut.gain), 100);
        ticks(1);
        check("rev_gain_99", int'(dut.gain), 99);
        check("rev_busy", int'(ramp_busy), 1);
        ticks(395);
        check("down_gain_1", int'(dut.gain), 1);
        check("down_busy_1", int'(ramp_busy), 1);
        ticks(1);
        check("down_gain_0", int'(dut.gain), 0);
        check("down_idle_busy", int'(ramp_busy), 0);
        check("down_idle_state", int'(dut.state), int'(ST_IDLE));
        ticks(1);
        check("idle_stays", int'(dut.state), int'(ST_IDLE));

        // Ramp to 60, then down to 57 and reset asynchronously mid-ramp
        mute = 1'b0;
        ticks(241);
        check("up_gain_60", int'(dut.gain), 60);
        mute = 1'b1;
        ticks(12);
        check("down_gain_57", int'(dut.gain), 57);
        check("down_57_busy", int'(ramp_busy), 1);
        #2;
        nreset = 1'b0;
        #1;
        check("async_rst_gain", int'(dut.gain), 0);
        check("async_rst_busy", int'(ramp_busy), 0);
        check("async_rst_running", int'(running), 0);
        check("async_rst_dac", int'(dac_out), 0);
        check("async_rst_state", int'(dut.state), int'(ST_IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        model_reset();
        last_sample = 1024;
        eg = 0;

        // Muted after reset: stays idle; input toggles every clk
        for (int k = 0; k < 4; k++) begin
            a = 11'(300 + k * 7);
            b = 11'(1700 - k * 5);
            tick_step(a, b, 1'b1);
            model_tick(int'(b));
            check("idle_dac_vs_model", int'(dac_out), int'(m_dac));
        end
        check("post_rst_idle", int'(dut.state), int'(ST_IDLE));
        check("post_rst_busy", int'(ramp_busy), 0);

        // Full ramp up with a toggling input, bit-exact against the model
        mute = 1'b0;
        for (int k = 1; k <= 1030; k++) begin
            a = 11'(512 + (k * 37) % 1024);
            b = 11'(512 + (k * 53) % 1024);
            tick_step(a, b, k <= 8);
            model_tick(int'(b));
            check("ramp_dac_vs_model", int'(dac_out), int'(m_dac));
            eg = ((k - 1) / 4 > 256) ? 256 : (k - 1) / 4;
            if (k == 1024) begin
                check("ramp_255_gain", int'(dut.gain), 255);
                check("ramp_255_busy", int'(ramp_busy), 1);
                check("ramp_255_running", int'(running), 0);
            end
            if (k == 1025) begin
                check("run_gain", int'(dut.gain), 256);
                check("run_busy", int'(ramp_busy), 0);
                check("run_running", int'(running), 1);
            end
        end

        // Density at full gain: x=+512 -> 3/4, x=-512 -> 1/4, x=0 -> 1/2
        ones = 0;
        run_model_ticks(256, 11'd1536, 1'b0);
        run_model_ticks(2048, 11'd1536, 1'b1);
        check($sformatf("density_1536 ones=%0d", ones), int'(ones >= 1526 && ones <= 1546), 1);
        ones = 0;
        run_model_ticks(256, 11'd512, 1'b0);
        run_model_ticks(2048, 11'd512, 1'b1);
        check($sformatf("density_512 ones=%0d", ones), int'(ones >= 502 && ones <= 522), 1);
        ones = 0;
        run_model_ticks(64, 11'd1024, 1'b0);
        run_model_ticks(256, 11'd1024, 1'b1);
        check($sformatf("density_mid ones=%0d", ones), int'(ones >= 126 && ones <= 130), 1);
        check("run_still_running", int'(running), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
